// File: rtl/ddram_pkg.sv
// Shared types for the DDRAM read-back scrub checker.
package ddram_pkg;

  localparam int unsigned DDR_ADDR_W = 29;
  localparam int unsigned DDR_BCNT_W = 8;

  typedef logic [DDR_ADDR_W-1:0] ddr_addr_t;
  typedef logic [DDR_BCNT_W-1:0] ddr_bcnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/ddram_scrub_checker_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             RESET,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ddram_scrub_checker.sv
// Reads back a cleared DDR3 region in bursts and compares every beat with the
// fill pattern; reports pass/fail, a saturating error count and first bad address.
module ddram_scrub_checker
  import ddram_pkg::*;
#(
  parameter int unsigned ADDR_W = DDR_ADDR_W,
  parameter int unsigned BURST  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk_sys,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     num_words,
  input  logic [63:0]           pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [ADDR_W-1:0]     first_err_addr,
  input  logic                  DDRAM_BUSY,
  output logic [DDR_BCNT_W-1:0] DDRAM_BURSTCNT,
  output logic [ADDR_W-1:0]     DDRAM_ADDR,
  output logic                  DDRAM_RD,
  input  logic [63:0]           DDRAM_DOUT,
  input  logic                  DDRAM_DOUT_READY
);

  localparam ddr_bcnt_t BURST_LEN = DDR_BCNT_W'(BURST);

  state_t            r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr,   w_cur_addr_nxt;
  logic [ADDR_W-1:0] r_remaining,  w_remaining_nxt;
  logic [63:0]       r_pattern,    w_pattern_nxt;
  logic [ADDR_W-1:0] r_beat_addr,  w_beat_addr_nxt;
  ddr_bcnt_t         r_beats_left, w_beats_left_nxt;
  logic              r_rd,         w_rd_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  ddr_bcnt_t         r_bcnt,       w_bcnt_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_done,       w_done_nxt;
  logic              r_pass,       w_pass_nxt;
  logic [ADDR_W-1:0] r_first_err,  w_first_err_nxt;

  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_err_cnt;
  logic             w_mismatch;
  ddr_bcnt_t        w_len;

  assign w_mismatch = (DDRAM_DOUT != r_pattern);
  assign w_len      = (r_remaining > ADDR_W'(BURST)) ? BURST_LEN
                                                     : DDR_BCNT_W'(r_remaining);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_cnt   (w_err_cnt)
  );

  // State and registered outputs
  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_pattern    <= '0;
      r_beat_addr  <= '0;
      r_beats_left <= '0;
      r_rd         <= 1'b0;
      r_addr       <= '0;
      r_bcnt       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_first_err  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_addr   <= w_cur_addr_nxt;
      r_remaining  <= w_remaining_nxt;
      r_pattern    <= w_pattern_nxt;
      r_beat_addr  <= w_beat_addr_nxt;
      r_beats_left <= w_beats_left_nxt;
      r_rd         <= w_rd_nxt;
      r_addr       <= w_addr_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_first_err  <= w_first_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cur_addr_nxt   = r_cur_addr;
    w_remaining_nxt  = r_remaining;
    w_pattern_nxt    = r_pattern;
    w_beat_addr_nxt  = r_beat_addr;
    w_beats_left_nxt = r_beats_left;
    w_rd_nxt         = r_rd;
    w_addr_nxt       = r_addr;
    w_bcnt_nxt       = r_bcnt;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_pass_nxt       = r_pass;
    w_first_err_nxt  = r_first_err;
    w_cnt_clr        = 1'b0;
    w_cnt_inc        = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_cur_addr_nxt  = base_addr;
          w_remaining_nxt = num_words;
          w_pattern_nxt   = pattern;
          w_first_err_nxt = '0;
          w_cnt_clr       = 1'b1;
          w_busy_nxt      = 1'b1;
          w_done_nxt      = 1'b0;
          w_pass_nxt      = 1'b0;
          w_state_nxt     = (num_words == '0) ? DONE : REQ;
        end
      end

      // Request is presented one cycle after entry and held until not busy
      REQ: begin
        if (!r_rd) begin
          w_rd_nxt   = 1'b1;
          w_addr_nxt = r_cur_addr;
          w_bcnt_nxt = w_len;
        end else if (!DDRAM_BUSY) begin
          w_rd_nxt         = 1'b0;
          w_beats_left_nxt = r_bcnt;
          w_beat_addr_nxt  = r_addr;
          w_state_nxt      = DATA;
        end
      end

      DATA: begin
        if (DDRAM_DOUT_READY) begin
          w_beat_addr_nxt  = r_beat_addr + ADDR_W'(1);
          w_beats_left_nxt = r_beats_left - DDR_BCNT_W'(1);
          if (w_mismatch) begin
            w_cnt_inc = 1'b1;
            if (w_err_cnt == '0) begin
              w_first_err_nxt = r_beat_addr;
            end
          end
          if (r_beats_left == DDR_BCNT_W'(1)) begin
            w_remaining_nxt = r_remaining - ADDR_W'(r_bcnt);
            w_cur_addr_nxt  = r_cur_addr + ADDR_W'(r_bcnt);
            w_state_nxt     = (r_remaining == ADDR_W'(r_bcnt)) ? DONE : REQ;
          end
        end
      end

      DONE: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_pass_nxt  = (w_err_cnt == '0);
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = w_err_cnt;
  assign first_err_addr = r_first_err;
  assign DDRAM_RD       = r_rd;
  assign DDRAM_ADDR     = r_addr;
  assign DDRAM_BURSTCNT = r_bcnt;

endmodule

// File: tb/tb_ddram_scrub_checker.sv
// Bench for ddram_scrub_checker: DDRAM responder model, burst scoreboard,
// table of region checks and hand-written reset / restart sequences.
module tb_ddram_scrub_checker;

  localparam int unsigned ADDR_W = 29;
  localparam int unsigned BURST  = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk_sys = 1'b0;
  logic              RESET = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_words = '0;
  logic [63:0]       pattern = '0;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_err_addr;
  logic              DDRAM_BUSY = 1'b0;
  logic [7:0]        DDRAM_BURSTCNT;
  logic [ADDR_W-1:0] DDRAM_ADDR;
  logic              DDRAM_RD;
  logic [63:0]       DDRAM_DOUT = '0;
  logic              DDRAM_DOUT_READY = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ddram_scrub_checker #(
    .ADDR_W (ADDR_W),
    .BURST  (BURST),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_sys          (clk_sys),
    .RESET            (RESET),
    .start            (start),
    .base_addr        (base_addr),
    .num_words        (num_words),
    .pattern          (pattern),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_cnt          (err_cnt),
    .first_err_addr   (first_err_addr),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } burst_t;

  burst_t exp_q[$];

  // Memory model configuration: beats in [err_lo, err_lo+err_n) return pattern^1
  logic [63:0]       m_pattern = '0;
  logic [ADDR_W-1:0] m_err_lo  = '0;
  int unsigned       m_err_n   = 0;
  int unsigned       m_busy_cycles = 0;
  bit                m_gap = 1'b0;

  int                cyc = 0;
  int                last_beat_cyc = 0;
  int                beats_left = 0;
  int                beats_delivered = 0;
  int                rd_cycles = 0;
  logic [ADDR_W-1:0] beat_addr = '0;
  bit                gap_t = 1'b0;
  bit                req_seen = 1'b0;
  bit                hold_chk = 1'b0;
  int                busy_ctr = 0;
  logic [ADDR_W-1:0] held_addr = '0;
  logic [7:0]        held_len = '0;

  function automatic logic [63:0] beat_data(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - m_err_lo;
    return (32'(off) < m_err_n) ? (m_pattern ^ 64'h1) : m_pattern;
  endfunction

  always @(posedge clk_sys) cyc++;

  // DDRAM responder: waitrequest, burst scoreboard and beat delivery
  always @(negedge clk_sys) begin
    burst_t b;
    DDRAM_DOUT_READY = 1'b0;
    if (beats_left > 0) begin
      gap_t = ~gap_t;
      if (!m_gap || gap_t) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT       = beat_data(beat_addr);
        beat_addr        = beat_addr + ADDR_W'(1);
        beats_left--;
        beats_delivered++;
        last_beat_cyc    = cyc;
      end
    end
    if (DDRAM_RD) begin
      rd_cycles++;
      if (hold_chk) begin
        check("rd_hold_addr", 64'(DDRAM_ADDR), 64'(held_addr));
        check("rd_hold_len", 64'(DDRAM_BURSTCNT), 64'(held_len));
      end
      if (!req_seen) begin
        req_seen = 1'b1;
        busy_ctr = int'(m_busy_cycles);
      end
      if (busy_ctr > 0) begin
        DDRAM_BUSY = 1'b1;
        busy_ctr--;
        hold_chk  = 1'b1;
        held_addr = DDRAM_ADDR;
        held_len  = DDRAM_BURSTCNT;
      end else begin
        DDRAM_BUSY = 1'b0;
        hold_chk   = 1'b0;
        req_seen   = 1'b0;
        if (exp_q.size() == 0) begin
          check("req_queue_depth", 64'(exp_q.size()), 64'd1);
        end else begin
          b = exp_q.pop_front();
          check("req_addr", 64'(DDRAM_ADDR), 64'(b.addr));
          check("req_len", 64'(DDRAM_BURSTCNT), 64'(b.len));
        end
        beats_left = int'(DDRAM_BURSTCNT);
        beat_addr  = DDRAM_ADDR;
        gap_t      = 1'b0;
      end
    end else begin
      DDRAM_BUSY = 1'b0;
      hold_chk   = 1'b0;
      req_seen   = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic push_bursts(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] rem;
    burst_t e;
    a   = b;
    rem = n;
    while (rem != '0) begin
      e.addr = a;
      e.len  = (rem > ADDR_W'(BURST)) ? 8'(BURST) : 8'(rem);
      exp_q.push_back(e);
      a   = a + ADDR_W'(e.len);
      rem = rem - ADDR_W'(e.len);
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                             input logic [63:0] p);
    tick();
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    pattern   = p;
    tick();
    start = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_done", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input bit chk_lat);
    for (int k = 0; k < 2000; k++) begin
      if (done) break;
      tick();
    end
    if (!done) begin
      check("done_timeout", 64'(done), 64'd1);
    end else if (chk_lat) begin
      check("done_latency", 64'(cyc - last_beat_cyc), 64'd2);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_first_err"}, 64'(first_err_addr), 64'd0);
    check({tag, "_rd"}, 64'(DDRAM_RD), 64'd0);
    check({tag, "_bcnt"}, 64'(DDRAM_BURSTCNT), 64'd0);
    check({tag, "_addr"}, 64'(DDRAM_ADDR), 64'd0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] num;
    logic [63:0]       pat;
    logic [ADDR_W-1:0] err_lo;
    int unsigned       err_n;
    int unsigned       busy_cyc;
    bit                gap;
    logic [CNT_W-1:0]  exp_err;
    logic [ADDR_W-1:0] exp_first;
    bit                exp_pass;
    int                exp_bursts;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    m_pattern       = v.pat;
    m_err_lo        = v.err_lo;
    m_err_n         = v.err_n;
    m_busy_cycles   = v.busy_cyc;
    m_gap           = v.gap;
    rd_cycles       = 0;
    beats_delivered = 0;
    push_bursts(v.base, v.num);
    pulse_start(v.base, v.num, v.pat);
    wait_done(1'b1);
    check($sformatf("v%0d_err_cnt", i), 64'(err_cnt), 64'(v.exp_err));
    check($sformatf("v%0d_first_err", i), 64'(first_err_addr), 64'(v.exp_first));
    check($sformatf("v%0d_pass", i), 64'(pass), 64'(v.exp_pass));
    check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
    check($sformatf("v%0d_beats", i), 64'(beats_delivered), 64'(v.num));
    check($sformatf("v%0d_q_left", i), 64'(exp_q.size()), 64'd0);
    check($sformatf("v%0d_rd_cycles", i), 64'(rd_cycles),
          64'(v.exp_bursts * (int'(v.busy_cyc) + 1)));
  endtask

  initial begin
    vecs[0] = '{29'h100, 29'd16, 64'h0, 29'h0, 0, 0, 1'b0, 4'h0, 29'h0, 1'b1, 2};
    vecs[1] = '{29'h100, 29'd16, 64'h0, 29'h105, 1, 0, 1'b0, 4'h1, 29'h105, 1'b0, 2};
    vecs[2] = '{29'h200, 29'd20, 64'hDEADBEEF_CAFEF00D, 29'h0, 0, 5, 1'b0, 4'h0, 29'h0, 1'b1, 3};
    vecs[3] = '{29'h300, 29'd20, 64'h5555_5555_5555_5555, 29'h300, 20, 0, 1'b1, 4'hF, 29'h300, 1'b0, 3};
    vecs[4] = '{29'h1FFF_FFFC, 29'd10, 64'hFFFF_FFFF_FFFF_FFFF, 29'h2, 1, 1, 1'b0, 4'h1, 29'h2, 1'b0, 2};
    vecs[5] = '{29'h40, 29'd3, 64'h0123_4567_89AB_CDEF, 29'h41, 2, 0, 1'b0, 4'h2, 29'h41, 1'b0, 1};

    // Reset with a coincident start that must be ignored
    RESET     = 1'b0;
    start     = 1'b1;
    base_addr = 29'h10;
    num_words = 29'd5;
    repeat (3) tick();
    check_reset_vals("por");
    RESET = 1'b1;
    start = 1'b0;
    tick();
    check("por_start_ignored_busy", 64'(busy), 64'd0);
    check("por_start_ignored_rd", 64'(rd_cycles), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Empty region: done two cycles after start, never any read
    rd_cycles = 0;
    pulse_start(29'h777, 29'd0, 64'h0);
    tick();
    check("zero_done", 64'(done), 64'd1);
    check("zero_pass", 64'(pass), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_err_cnt", 64'(err_cnt), 64'd0);
    repeat (3) tick();
    check("zero_done_sticky", 64'(done), 64'd1);
    check("zero_no_rd", 64'(rd_cycles), 64'd0);

    // Start while busy must not restart the check
    m_pattern = 64'h0; m_err_n = 0; m_busy_cycles = 2; m_gap = 1'b0;
    rd_cycles = 0; beats_delivered = 0;
    push_bursts(29'h400, 29'd16);
    pulse_start(29'h400, 29'd16, 64'h0);
    repeat (6) tick();
    start     = 1'b1;
    base_addr = 29'h999;
    num_words = 29'd3;
    pattern   = 64'h1234;
    tick();
    start = 1'b0;
    wait_done(1'b1);
    check("restart_beats", 64'(beats_delivered), 64'd16);
    check("restart_q_left", 64'(exp_q.size()), 64'd0);
    check("restart_pass", 64'(pass), 64'd1);
    check("restart_err_cnt", 64'(err_cnt), 64'd0);

    // Reset in the middle of a burst of all-bad beats
    m_pattern = 64'h0; m_err_lo = 29'h500; m_err_n = 8; m_busy_cycles = 0;
    beats_delivered = 0;
    push_bursts(29'h500, 29'd8);
    pulse_start(29'h500, 29'd8, 64'h0);
    for (int k = 0; k < 100; k++) begin
      if (beats_delivered >= 3) break;
      tick();
    end
    check("rst_mid_reached", 64'(beats_delivered >= 3), 64'd1);
    tick();
    RESET = 1'b0;
    tick();
    check_reset_vals("rst_mid");
    RESET = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (beats_left == 0) break;
      tick();
    end
    repeat (2) tick();
    check("rst_trail_beats", 64'(beats_delivered), 64'd8);
    check("rst_trail_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_trail_first", 64'(first_err_addr), 64'd0);
    check("rst_trail_busy", 64'(busy), 64'd0);
    check("rst_trail_done", 64'(done), 64'd0);
    check("rst_q_left", 64'(exp_q.size()), 64'd0);

    run_vec(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
